// File: rtl/alu_arb_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes, FSM encoding
// and the 5-bit ALU evaluation helper used by the datapath.
package alu_arb_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns {carry, result}; unused opcodes answer with all zeros.
    function automatic logic [4:0] alu_eval(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [2:0] sel);
        logic [4:0] res;
        res = 5'd0;
        case (sel)
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            default: res = 5'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU shared by all requesters of the arbiter.
module alu_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel,
    output logic [3:0] out,
    output logic       carry
);
    import alu_arb_pkg::*;

    logic [4:0] res_s;

    // Evaluate the selected operation.
    always_comb begin
        res_s = alu_eval(a, b, sel);
    end

    assign out   = res_s[3:0];
    assign carry = res_s[4];

endmodule

// File: rtl/alu_4bit_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after rr_ptr.
module alu_4bit_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_grant
);
    logic [N_REQ-1:0] rot_s;
    logic [ID_W-1:0]  off_s;
    logic [ID_W:0]    sum_s;

    // Rotate so that bit k of rot_s is requester (rr_ptr + k) mod N_REQ.
    assign rot_s = N_REQ'({req, req} >> rr_ptr);

    // Lowest set offset wins; the offset is then mapped back to an index.
    always_comb begin
        off_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? ID_W'(k) : off_s;
        end
        sum_s     = {1'b0, rr_ptr} + {1'b0, off_s};
        grant_idx = (sum_s >= (ID_W+1)'(N_REQ)) ? ID_W'(sum_s - (ID_W+1)'(N_REQ))
                                                : sum_s[ID_W-1:0];
    end

    assign any_grant = |req;

endmodule

// File: rtl/alu_4bit_arbiter.sv
// Round-robin arbiter sharing one alu_4bit among N_REQ requesters.
// Optional rsp_zero output enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_4bit_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_result,
    output logic                 rsp_carry
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic                 rsp_zero
`endif
);
    state_t          state_r, state_nx_s;
    logic [ID_W-1:0] rr_ptr_r, grant_idx_s, id_r;
    logic            any_grant_s, grant_en_s;
    logic [3:0]      a_r, b_r, mux_a_s, mux_b_s, alu_out_s;
    logic [2:0]      sel_r, mux_sel_s;
    logic            alu_carry_s;
    logic            rsp_valid_r, rsp_carry_r;
    logic [ID_W-1:0] rsp_id_r;
    logic [3:0]      rsp_result_r;

    alu_4bit_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    alu_4bit u_alu (
        .a     (a_r),
        .b     (b_r),
        .sel   (sel_r),
        .out   (alu_out_s),
        .carry (alu_carry_s)
    );

    // Select the granted requester's operands.
    always_comb begin
        mux_a_s   = 4'd0;
        mux_b_s   = 4'd0;
        mux_sel_s = 3'd0;
        for (int i = 0; i < N_REQ; i++) begin
            mux_a_s   = (grant_idx_s == ID_W'(i)) ? req_a[4*i +: 4]   : mux_a_s;
            mux_b_s   = (grant_idx_s == ID_W'(i)) ? req_b[4*i +: 4]   : mux_b_s;
            mux_sel_s = (grant_idx_s == ID_W'(i)) ? req_sel[3*i +: 3] : mux_sel_s;
        end
    end

    // Next-state and grant logic; req_ready is gated by reset so nothing is accepted in reset.
    always_comb begin
        state_nx_s = state_r;
        req_ready  = '0;
        grant_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_grant_s && rst_n) begin
                    req_ready  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
                    grant_en_s = 1'b1;
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nx_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand latch, round-robin pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            a_r          <= 4'd0;
            b_r          <= 4'd0;
            sel_r        <= 3'd0;
            id_r         <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= 4'd0;
            rsp_carry_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (grant_en_s) begin
                a_r      <= mux_a_s;
                b_r      <= mux_b_s;
                sel_r    <= mux_sel_s;
                id_r     <= grant_idx_s;
                rr_ptr_r <= (grant_idx_s == ID_W'(N_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
            end
            if (state_r == ST_EXEC) begin
                rsp_valid_r  <= 1'b1;
                rsp_id_r     <= id_r;
                rsp_result_r <= alu_out_s;
                rsp_carry_r  <= alu_carry_s;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_ZERO_FLAG_EN
    logic rsp_zero_r;

    // Zero flag captured together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_zero_r <= (alu_out_s == 4'd0);
        end
    end

    assign rsp_zero = rsp_zero_r;
`endif

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_carry  = rsp_carry_r;

endmodule

// File: tb/tb_alu_4bit_arbiter.sv
// Self-checking bench for alu_4bit_arbiter: transaction-level model plus directed pins.
module tb_alu_4bit_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_a, req_b;
    logic [3*N-1:0] req_sel;
    logic           rsp_valid, rsp_ready, rsp_carry;
    logic [1:0]     rsp_id;
    logic [3:0]     rsp_result;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic           rsp_zero;
`endif

    alu_4bit_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry)
`ifdef ALU_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero   (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    bit p_valid[N];
    int p_a[N], p_b[N], p_sel[N];
    bit rnd_mode = 1'b0;
    bit refill_all = 1'b0;

    // Model: at most one transaction; response visible from grant cycle + 2 until consumed.
    bit m_txn = 1'b0;
    int m_t, m_id, m_res, m_carry;
    int m_ptr = 0;

    int dut_grant_q[$];
    int log_id[$], log_res[$], log_carry[$], log_zero[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void model_op(input int a, input int b, input int sel,
                                     output int res, output int carry);
        int d;
        res = 0;
        carry = 0;
        case (sel)
            0: begin res = (a + b) % 16; carry = ((a + b) >= 16) ? 1 : 0; end
            1: begin d = a - b; res = (d + 16) % 16; carry = (d < 0) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            default: begin res = 0; carry = 0; end
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = p_valid[i];
            req_a[4*i +: 4]     = 4'(p_a[i]);
            req_b[4*i +: 4]     = 4'(p_b[i]);
            req_sel[3*i +: 3]   = 3'(p_sel[i]);
        end
    endtask

    task automatic model_reset();
        m_txn = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then update stimulus.
    task automatic step();
        int g, dg, exp_ready;
        bit exp_valid;
        @(negedge clk);
        exp_valid = m_txn && (cyc >= m_t + 2);
        g = -1;
        if (!m_txn && rst_n) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (p_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = (g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), exp_ready);
        chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
        dg = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dg = i;
        if (dg >= 0) dut_grant_q.push_back(dg);
        if (exp_valid) begin
            chk("rsp_id", int'(rsp_id), m_id);
            chk("rsp_result", int'(rsp_result), m_res);
            chk("rsp_carry", int'(rsp_carry), m_carry);
`ifdef ALU_ARB_ZERO_FLAG_EN
            chk("rsp_zero", int'(rsp_zero), (m_res == 0) ? 1 : 0);
`endif
            if (rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_res.push_back(int'(rsp_result));
                log_carry.push_back(int'(rsp_carry));
`ifdef ALU_ARB_ZERO_FLAG_EN
                log_zero.push_back(int'(rsp_zero));
`endif
                m_txn = 1'b0;
            end
        end
        if (g >= 0) begin
            m_txn = 1'b1;
            m_t   = cyc;
            m_id  = g;
            model_op(p_a[g], p_b[g], p_sel[g], m_res, m_carry);
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (g >= 0) p_valid[g] = 1'b0;
        if (refill_all) for (int i = 0; i < N; i++) p_valid[i] = 1'b1;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i] && ($urandom_range(3) == 0)) begin
                    p_valid[i] = 1'b1;
                    p_a[i]     = $urandom_range(15);
                    p_b[i]     = $urandom_range(15);
                    p_sel[i]   = $urandom_range(7);
                end else if (p_valid[i] && ($urandom_range(15) == 0)) begin
                    p_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
        end
        drive();
    endtask

    task automatic run_until_rsp(input string name, input int target);
        for (int n = 0; n < 40 && log_id.size() < target; n++) step();
        chk(name, (log_id.size() >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b1; p_a[i] = 15; p_b[i] = 15; p_sel[i] = 0;
        end
        drive();
        // Reset held with every requester valid.
        repeat (3) step();
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_result", int'(rsp_result), 0);
        chk("reset_rsp_carry", int'(rsp_carry), 0);
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        drive();
        rst_n = 1'b1;
        step();

        // Single add on requester 0: 9 + 8 = 17.
        p_valid[0] = 1'b1; p_a[0] = 9; p_b[0] = 8; p_sel[0] = 0;
        drive();
        dut_grant_q.delete();
        log_id.delete(); log_res.delete(); log_carry.delete(); log_zero.delete();
        step();
        step();
        chk("single_valid_t2", int'(rsp_valid), 1);
        run_until_rsp("single_done", 1);
        chk("single_grant", qat(dut_grant_q, 0), 0);
        chk("single_id", qat(log_id, 0), 0);
        chk("single_result", qat(log_res, 0), 1);
        chk("single_carry", qat(log_carry, 0), 1);

        // Contention from a fresh pointer: all valid, 3 - 5.
        rst_n = 1'b0; model_reset(); drive(); step(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b1; p_a[i] = 3; p_b[i] = 5; p_sel[i] = 1;
        end
        refill_all = 1'b1;
        drive();
        dut_grant_q.delete();
        log_id.delete(); log_res.delete(); log_carry.delete(); log_zero.delete();
        run_until_rsp("contend_done", 5);
        for (int i = 0; i < 5; i++) begin
            chk("contend_grant", qat(dut_grant_q, i), i % 4);
            chk("contend_id", qat(log_id, i), i % 4);
            chk("contend_result", qat(log_res, i), 14);
            chk("contend_carry", qat(log_carry, i), 1);
        end

        // Backpressure: hold the response for several cycles, then release.
        rsp_ready = 1'b0;
        for (int n = 0; n < 10 && !rsp_valid; n++) step();
        chk("bp_valid", int'(rsp_valid), 1);
        n0 = dut_grant_q.size();
        repeat (5) step();
        chk("bp_no_grant", dut_grant_q.size(), n0);
        rsp_ready = 1'b1;
        step();
        step();
        chk("bp_next_grant", qat(dut_grant_q, n0), (qat(dut_grant_q, n0 - 1) + 1) % 4);
        refill_all = 1'b0;
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        drive();
        repeat (4) step();

        // Unused opcode is answered with zeros.
        p_valid[3] = 1'b1; p_a[3] = 15; p_b[3] = 15; p_sel[3] = 7;
        drive();
        n0 = log_id.size();
        run_until_rsp("illegal_done", n0 + 1);
        chk("illegal_id", qat(log_id, n0), 3);
        chk("illegal_result", qat(log_res, n0), 0);
        chk("illegal_carry", qat(log_carry, n0), 0);

`ifdef ALU_ARB_ZERO_FLAG_EN
        // 5 xor 5 gives a zero result.
        p_valid[0] = 1'b1; p_a[0] = 5; p_b[0] = 5; p_sel[0] = 4;
        drive();
        n0 = log_id.size();
        run_until_rsp("zero_done", n0 + 1);
        chk("zero_flag", qat(log_zero, n0), 1);
`endif

        // Reset while requester 2 is in execution; pointer must return to 0.
        step();
        p_valid[2] = 1'b1; p_a[2] = 7; p_b[2] = 1; p_sel[2] = 0;
        drive();
        n0 = dut_grant_q.size();
        step();
        chk("midop_grant", qat(dut_grant_q, n0), 2);
        rst_n = 1'b0;
        model_reset();
        drive();
        #1;
        chk("midop_rsp_valid", int'(rsp_valid), 0);
        chk("midop_rsp_id", int'(rsp_id), 0);
        chk("midop_rsp_result", int'(rsp_result), 0);
        chk("midop_rsp_carry", int'(rsp_carry), 0);
        step();
        step();
        rst_n = 1'b1;
        p_valid[1] = 1'b1; p_a[1] = 2; p_b[1] = 2; p_sel[1] = 0;
        p_valid[3] = 1'b1; p_a[3] = 4; p_b[3] = 1; p_sel[3] = 1;
        drive();
        n0 = dut_grant_q.size();
        step();
        chk("post_reset_grant", qat(dut_grant_q, n0), 1);

        // Randomized traffic against the model.
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
        drive();
        repeat (6) step();

        // Full operand/opcode sweep through requester 2.
        for (int s = 0; s < 5; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    p_valid[2] = 1'b1; p_a[2] = a; p_b[2] = b; p_sel[2] = s;
                    drive();
                    n0 = log_id.size();
                    for (int n = 0; n < 20 && log_id.size() == n0; n++) step();
                    chk("sweep_rsp", log_id.size(), n0 + 1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
